// File: rtl/gray_dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_dec_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one registered Gray-to-
//            binary decoder among N_REQ requesters. One requester is granted
//            at a time. Its Gray word is driven to the decoder, the decoder
//            latency is waited out, and the binary result is returned with a
//            one-cycle ack.
// Ports    : clk       - system clock, rising edge
//            rst       - asynchronous reset, active-low
//            req       - per-requester request level, held until ack
//            gray_in   - packed Gray words, requester i at [i*WIDTH +: WIDTH]
//            ack       - one-hot, one-cycle pulse to the served requester
//            dec_gray  - registered Gray word to the decoder
//            dec_bin   - decoder binary output
//            rsp_bin   - registered result, held after rsp_valid
//            rsp_id    - index of the served requester
//            rsp_valid - one-cycle pulse, coincident with ack
//            busy      - high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module gray_dec_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int DEC_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WIDTH-1:0]    gray_in,
    output logic [N_REQ-1:0]          ack,
    output logic [WIDTH-1:0]          dec_gray,
    input  logic [WIDTH-1:0]          dec_bin,
    output logic [WIDTH-1:0]          rsp_bin,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic                      rsp_valid,
    output logic                      busy
);

    localparam int c_IDW = $clog2(N_REQ);
    localparam int c_CW  = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    // Pointer starts at the last requester so requester 0 has first priority.
    localparam logic [c_IDW-1:0] c_LAST_RST = c_IDW'(N_REQ - 1);
    localparam logic [c_CW-1:0]  c_CNT_LOAD = c_CW'(DEC_LAT - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
    localparam logic [N_REQ-1:0] c_ACK_ONE  = N_REQ'(1);
    localparam logic [c_IDW:0]   c_NREQ_EXT = (c_IDW + 1)'(N_REQ);

    logic [1:0]       r_state;
    logic [c_IDW-1:0] r_last;
    logic [c_IDW-1:0] r_gid;
    logic [c_CW-1:0]  r_cnt;

    logic             w_any;
    logic [c_IDW-1:0] w_winner;
    logic [c_IDW:0]   w_sum;
    logic [WIDTH-1:0] w_win_gray;

    // Search last+1, last+2, ... with wrap; the first set bit wins. One extra
    // bit on the sum keeps the wrap compare exact for non-power-of-two N_REQ.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, r_last} + (c_IDW + 1)'(k);
            if (w_sum >= c_NREQ_EXT) begin
                w_sum = w_sum - c_NREQ_EXT;
            end
            if (!w_any && req[w_sum[c_IDW-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_sum[c_IDW-1:0];
            end
        end
    end

    assign w_win_gray = gray_in[int'(w_winner)*WIDTH +: WIDTH];
    assign busy       = (r_state != c_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_last    <= c_LAST_RST;
            r_gid     <= '0;
            r_cnt     <= '0;
            dec_gray  <= '0;
            rsp_bin   <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            ack       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            ack       <= '0;
            case (r_state)
                c_IDLE: begin
                    // dec_gray is only loaded at a grant and otherwise held.
                    if (w_any) begin
                        r_gid    <= w_winner;
                        r_last   <= w_winner;
                        dec_gray <= w_win_gray;
                        r_state  <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt   <= c_CNT_LOAD;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end else begin
                        rsp_bin   <= dec_bin;
                        rsp_id    <= r_gid;
                        rsp_valid <= 1'b1;
                        ack       <= c_ACK_ONE << r_gid;
                        r_state   <= c_RESP;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_dec_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_dec_arbiter
// Purpose  : Self-checking bench for gray_dec_arbiter. Includes a registered
//            Gray-to-binary decoder model, a vector table, hand-written
//            sequences and a randomized run against a timing/arbitration
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_dec_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int L   = 1;
    localparam int IDW = $clog2(N);

    logic               clk;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*W-1:0]     gray_in;
    logic [N-1:0]       ack;
    logic [W-1:0]       dec_gray;
    logic [W-1:0]       dec_bin;
    logic [W-1:0]       rsp_bin;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_valid;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    gray_dec_arbiter #(.N_REQ(N), .WIDTH(W), .DEC_LAT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gray_in   (gray_in),
        .ack       (ack),
        .dec_gray  (dec_gray),
        .dec_bin   (dec_bin),
        .rsp_bin   (rsp_bin),
        .rsp_id    (rsp_id),
        .rsp_valid (rsp_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Binary bit i is the XOR of all Gray bits at positions >= i.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // External decoder: L register stages.
    logic [W-1:0] dec_pipe [L];
    always_ff @(posedge clk) begin
        dec_pipe[0] <= g2b(dec_gray);
        for (int k = 1; k < L; k++) dec_pipe[k] <= dec_pipe[k-1];
    end
    assign dec_bin = dec_pipe[L-1];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for rsp_valid and checks the response fields.
    task automatic expect_rsp(input string nm, input int max_cyc, input int exp_lat,
                              input int exp_id, input logic [W-1:0] exp_bin);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < max_cyc) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        check({nm, " seen"}, 32'(got), 32'd1);
        if (got) begin
            if (exp_lat >= 0) check({nm, " latency"}, lat, exp_lat);
            check({nm, " id"},  32'(rsp_id),  exp_id);
            check({nm, " bin"}, 32'(rsp_bin), 32'(exp_bin));
            check({nm, " ack"}, 32'(ack),     32'(N'(1) << exp_id));
        end
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] gray;
        int             id;
        logic [W-1:0]   bin;
    } vec_t;

    vec_t tbl [8];

    // Reference-model state for the randomized run.
    int           m_last, m_g, m_gid, e_id, cyc, cnt;
    bit           m_act, exp_busy, exp_valid;
    logic [W-1:0] m_gray, e_bin;
    logic [N-1:0] exp_ack;

    initial begin
        // Entries are applied in order from a fresh reset (pointer = N-1).
        tbl[0] = '{4'b0100, {4'b0000, 4'b0110, 4'b0000, 4'b0000}, 2, 4'b0100};
        tbl[1] = '{4'b1001, {4'b0011, 4'b0000, 4'b0000, 4'b1000}, 3, 4'b0010};
        tbl[2] = '{4'b1001, {4'b0011, 4'b0000, 4'b0000, 4'b1000}, 0, 4'b1111};
        tbl[3] = '{4'b0110, {4'b0000, 4'b0001, 4'b1111, 4'b0000}, 1, 4'b1010};
        tbl[4] = '{4'b0101, {4'b0000, 4'b1100, 4'b0000, 4'b0011}, 2, 4'b1000};
        tbl[5] = '{4'b0011, {4'b0000, 4'b0000, 4'b1010, 4'b0111}, 0, 4'b0101};
        tbl[6] = '{4'b1000, {4'b1011, 4'b0101, 4'b0110, 4'b1001}, 3, 4'b1101};
        tbl[7] = '{4'b0010, {4'b1111, 4'b1111, 4'b0000, 4'b1111}, 1, 4'b0000};

        // Reset held with all requests up, then round-robin with req held.
        rst     = 1'b0;
        req     = 4'b1111;
        gray_in = {4'b0001, 4'b1111, 4'b0011, 4'b1000};
        repeat (5) @(negedge clk);
        check("reset busy",      32'(busy),      32'd0);
        check("reset ack",       32'(ack),       32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset dec_gray",  32'(dec_gray),  32'd0);
        check("reset rsp_bin",   32'(rsp_bin),   32'd0);
        check("reset rsp_id",    32'(rsp_id),    32'd0);
        rst = 1'b1;
        expect_rsp("rr0", 10, L + 2, 0, 4'b1111);
        expect_rsp("rr1", 10, L + 3, 1, 4'b0010);
        expect_rsp("rr2", 10, L + 3, 2, 4'b1010);
        expect_rsp("rr3", 10, L + 3, 3, 4'b0001);
        expect_rsp("rr4", 10, L + 3, 0, 4'b1111);
        req = '0;
        @(negedge clk);
        check("rr idle", 32'(busy), 32'd0);

        // Vector table from a fresh reset.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 8; t++) begin
            req     = tbl[t].req;
            gray_in = tbl[t].gray;
            expect_rsp($sformatf("tbl%0d", t), 10, L + 2, tbl[t].id, tbl[t].bin);
            req = '0;
            @(negedge clk);
            check($sformatf("tbl%0d idle", t), 32'(busy), 32'd0);
        end

        // Late arrival: req[3] rises while requester 0 is in WAIT.
        req     = 4'b0001;
        gray_in = {4'b0000, 4'b0000, 4'b0000, 4'b0101};
        repeat (2) @(negedge clk);
        req[3]         = 1'b1;
        gray_in[15:12] = 4'b1110;
        expect_rsp("late id0", 10, -1, 0, 4'b0110);
        req[0] = 1'b0;
        expect_rsp("late id3", 10, L + 3, 3, 4'b1011);
        req = '0;
        @(negedge clk);
        check("late idle", 32'(busy), 32'd0);

        // Request dropped (and data changed) in the ISSUE cycle.
        req          = 4'b0010;
        gray_in[7:4] = 4'b1101;
        @(negedge clk);
        req          = '0;
        gray_in[7:4] = 4'b0000;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack[1]) cnt++;
            if (rsp_valid) begin
                check("drop id",  32'(rsp_id),  32'd1);
                check("drop bin", 32'(rsp_bin), 32'b1001);
                check("drop ack", 32'(ack),     32'b0010);
            end
        end
        check("drop ack count", cnt, 1);

        // Reset asserted during WAIT aborts the transaction.
        req            = 4'b0100;
        gray_in[11:8]  = 4'b0101;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst busy",     32'(busy),     32'd0);
        check("midrst dec_gray", 32'(dec_gray), 32'd0);
        req     = 4'b1110;
        gray_in = {4'b1001, 4'b0111, 4'b0010, 4'b0000};
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp_valid || ack != '0) cnt++;
        end
        check("midrst no response", cnt, 0);
        rst = 1'b1;
        expect_rsp("midrst first", 10, L + 2, 1, 4'b0011);
        req = '0;

        // Randomized run against the reference model.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        m_last = N - 1;
        m_act  = 1'b0;
        m_g    = 0;
        m_gid  = 0;
        m_gray = '0;
        e_bin  = '0;
        e_id   = 0;
        cyc    = 0;
        for (int it = 0; it < 1500; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    gray_in[i*W +: W] = W'($urandom);
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
            end
            // A grant can occur when idle, DEC_LAT+3 edges after the last one.
            if ((!m_act || cyc + 1 >= m_g + L + 3) && req != '0) begin
                int w;
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
                end
                m_act  = 1'b1;
                m_g    = cyc + 1;
                m_gid  = w;
                m_last = w;
                m_gray = gray_in[w*W +: W];
            end
            @(negedge clk);
            cyc++;
            exp_busy  = m_act && (cyc <= m_g + L + 1);
            exp_valid = m_act && (cyc == m_g + L + 1);
            if (exp_valid) begin
                e_bin = g2b(m_gray);
                e_id  = m_gid;
            end
            exp_ack = exp_valid ? (N'(1) << m_gid) : '0;
            check($sformatf("random cycle %0d {busy,valid,ack,id,bin,dec_gray}", cyc),
                  32'({busy, rsp_valid, ack, rsp_id, rsp_bin, dec_gray}),
                  32'({exp_busy, exp_valid, exp_ack, IDW'(e_id), e_bin, m_gray}));
            // A served requester either drops or re-requests with the same word.
            if (exp_valid && $urandom_range(0, 1) == 0) req[m_gid] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_dec_arbiter.md
Name: gray_dec_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered Gray-to-binary decoder (4-bit Gray in, 4-bit binary out, clocked) among N_REQ requesters.
- Grants one requester at a time, drives the captured Gray code into the decoder, and waits the decoder's fixed latency.
- Returns the binary result to the granted requester with a one-cycle ack.
- Sits between position/sensor front-ends and the single decoder instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, Gray/binary word width; must match the decoder.
- DEC_LAT, 1, decoder latency in clock edges from dec_gray stable to dec_bin valid (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- req  input  N_REQ  per-requester request level; held until matching ack bit.
- gray_in  input  N_REQ*WIDTH  packed Gray words; requester i owns bits [i*WIDTH +: WIDTH]; stable while req[i]=1.
- ack  output  N_REQ  one-hot, one-cycle pulse to the requester whose result is on rsp_bin.
- dec_gray  output  WIDTH  registered Gray word to the decoder's gray input.
- dec_bin  input  WIDTH  decoder bin output.
- rsp_bin  output  WIDTH  registered binary result; valid when rsp_valid=1, held afterwards.
- rsp_id  output  $clog2(N_REQ)  index of the requester served.
- rsp_valid  output  1  one-cycle pulse, coincident with ack.
- busy  output  1  1 in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ack=0, dec_gray=0, rsp_bin=0, rsp_id=0, rsp_valid=0, busy=0, wait counter=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is 1, pick the first set bit searching last+1, last+2, … with wrap modulo N_REQ.
  - At that edge register gid=winner, last=winner, dec_gray=gray_in[winner]; go to ISSUE.
  - If req=0, stay in IDLE.
- ISSUE: exactly 1 cycle; dec_gray is presented to the decoder. Load counter=DEC_LAT-1; go to WAIT.
- WAIT:
  - While counter!=0, decrement.
  - When counter==0, register rsp_bin=dec_bin and rsp_id=gid; go to RESP.
- RESP: exactly 1 cycle; rsp_valid=1 and ack[gid]=1, all other ack bits 0. Go to IDLE unconditionally.
- Latency, for a winner sampled at edge E0:
  - rsp_valid is high in the cycle after edge E0+DEC_LAT+1.
  - Minimum service period is DEC_LAT+3 cycles, i.e. 4 cycles at DEC_LAT=1.
- dec_gray stays constant from the grant edge until the next grant; it is not cleared in IDLE.
- Once granted, a transaction always completes. Deassertion of req[gid] or changes on gray_in after the grant edge are ignored, and the ack is still issued.
- Fairness: with all req bits held high, grants rotate 0,1,2,…,N_REQ-1,0. No requester waits more than N_REQ-1 transactions.
- Simultaneous events: a new req arriving during ISSUE/WAIT/RESP is only considered in IDLE. Requests are level-sensitive, so a pending req is not lost.
- A requester that keeps req high after its ack is eligible again, but only after the other pending requesters have been served.
- Reset asserted mid-transaction: the FSM aborts immediately to the reset state, no ack is issued for the aborted grant, and the pointer returns to N_REQ-1.
- Width rule: rsp_bin is a straight copy of dec_bin, with no arithmetic in this block. rsp_id is zero-extended when N_REQ is not a power of two.

Test Plan:
1. Reset: hold rst=0 for 5 cycles with req=4'b1111 -> busy=0, ack=0, rsp_valid=0, dec_gray=0. Release -> the first grant goes to requester 0.
2. Single request: req=4'b0100, gray_in[2]=4'b0110 -> rsp_valid pulses DEC_LAT+2 cycles after the grant edge, with rsp_id=2, rsp_bin=4'b0100, ack=4'b0100. busy returns to 0 the next cycle.
3. Round-robin: req=4'b1111 held, gray words 4'b1000, 4'b0011, 4'b1111, 4'b0001 -> responses in order id 0,1,2,3 with bin 1111, 0010, 1010, 0001, then id 0 again. Responses are 4 cycles apart.
4. Late arrival: req=4'b0001 granted; req[3] rises during WAIT -> id 0 completes first; id 3 is granted in the following IDLE cycle and no transaction is lost.
5. Request drop: req[1] deasserted in the ISSUE cycle -> the transaction still completes and ack[1] pulses once.
6. Mid-operation reset: assert rst=0 in WAIT -> no rsp_valid/ack for that grant. After release with req=4'b1110, the first grant goes to id 1.
